// File: rtl/rom_arbiter.sv
// Two-port round-robin front end for a single-ported, fixed-latency ROM.
// One access in flight; the response comes back as a one-cycle rvalid pulse to the winner.
module rom_arbiter #(
  parameter int unsigned ADDR_W  = 32,
  parameter int unsigned ROM_AW  = 10,
  parameter int unsigned ROM_LAT = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_ack,
  output logic              if_rvalid,
  output logic [31:0]       if_rdata,
  input  logic              d_req,
  input  logic [ADDR_W-1:0] d_addr,
  output logic              d_ack,
  output logic              d_rvalid,
  output logic [31:0]       d_rdata,
  output logic              rom_en,
  output logic [ROM_AW-1:0] rom_addr,
  input  logic [31:0]       rom_rdata,
  output logic              busy
);

  typedef enum logic [1:0] {StIdle, StIssue, StWait} state_e;

  localparam logic [2:0] LatCnt = 3'(ROM_LAT);

  state_e            state_q;
  logic              last_data_q;
  logic              grant_data_q;
  logic              oor_q;
  logic [2:0]        cnt_q;

  logic              pick_data;
  logic [ADDR_W-1:0] sel_addr;
  logic              in_range;
  logic              unused_addr_lsb;

  // Fetch wins a tie unless it was the last one served.
  always_comb begin
    pick_data = d_req & (~if_req | ~last_data_q);
    sel_addr  = pick_data ? d_addr : if_addr;
    in_range  = (sel_addr[ADDR_W-1:ROM_AW+2] == '0);
  end

  assign unused_addr_lsb = ^sel_addr[1:0];

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= StIdle;
      last_data_q  <= 1'b1;
      grant_data_q <= 1'b0;
      oor_q        <= 1'b0;
      cnt_q        <= '0;
      if_ack       <= 1'b0;
      d_ack        <= 1'b0;
      if_rvalid    <= 1'b0;
      d_rvalid     <= 1'b0;
      if_rdata     <= '0;
      d_rdata      <= '0;
      rom_en       <= 1'b0;
      rom_addr     <= '0;
      busy         <= 1'b0;
    end else begin
      if_ack    <= 1'b0;
      d_ack     <= 1'b0;
      if_rvalid <= 1'b0;
      d_rvalid  <= 1'b0;
      rom_en    <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (if_req || d_req) begin
            state_q      <= StIssue;
            busy         <= 1'b1;
            grant_data_q <= pick_data;
            last_data_q  <= pick_data;
            if_ack       <= ~pick_data;
            d_ack        <= pick_data;
            oor_q        <= ~in_range;
            cnt_q        <= LatCnt;
            // Out-of-range accesses keep the same timing but never touch the ROM.
            if (in_range) begin
              rom_en   <= 1'b1;
              rom_addr <= sel_addr[ROM_AW+1:2];
            end
          end
        end
        StIssue: begin
          state_q <= StWait;
          cnt_q   <= cnt_q - 3'd1;
        end
        StWait: begin
          if (cnt_q == 3'd0) begin
            state_q <= StIdle;
            busy    <= 1'b0;
            if (grant_data_q) begin
              d_rdata  <= oor_q ? 32'h0 : rom_rdata;
              d_rvalid <= 1'b1;
            end else begin
              if_rdata  <= oor_q ? 32'h0 : rom_rdata;
              if_rvalid <= 1'b1;
            end
          end else begin
            cnt_q <= cnt_q - 3'd1;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule
